oc8051_ram_bist: RTL and testbench
==================================

# oc8051_ram_bist

March C- built-in self-test engine for the 8051 internal data RAM. It sits on the RAM's write and read ports and drives `wr_addr`/`wr_data`/`wr`/`wr_en` and `rd_addr`/`rd_en`. It checks the registered `rd_data` returned one cycle after each read. It reports pass/fail with a captured failing address, observed data and expected data. The core muxes this block onto the RAM ports only while `busy` is high; that mux lives outside this block.

## Interface

- `DEPTH`, 16, number of RAM words tested, addresses 0..DEPTH-1; power of two, 2..256
- `PAT`, 8'h00, background for "0" writes; "1" writes use `~PAT`
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (low = reset)
- `start`  in  1  begin a test; sampled only in IDLE/DONE
- `busy`  out  1  test in progress
- `done`  out  1  test finished (pass or abort); held until next `start` or reset
- `fail`  out  1  mismatch detected; held with `done`
- `fail_addr`  out  8  address of first mismatch
- `fail_data`  out  8  `rd_data` observed at first mismatch
- `fail_exp`  out  8  expected value at first mismatch
- `wr_addr`  out  8  RAM write address; bits above log2(DEPTH) are 0
- `wr_data`  out  8  RAM write data
- `wr`  out  1  RAM write strobe
- `wr_en`  out  1  equals `wr`
- `rd_addr`  out  8  RAM read address
- `rd_en`  out  1  RAM read enable
- `rd_data`  in  8  RAM registered read data, valid the cycle after `rd_en`

## Operation

- States: IDLE, M0, M1, M2, M3, M4, M5, CHK, DONE.
- Address counter is log2(DEPTH) bits. Sub-phase bit `ph` is used by read/write elements.
- M0 ↑(w0): 1 cycle per address, a = 0..DEPTH-1; `wr`=1, `wr_data`=PAT.
- M1 ↑(r0,w1) and M2 ↑(r1,w0): 2 cycles per address.
  - ph=0: `rd_en`=1, `rd_addr`=a.
  - ph=1: `wr`=1, `wr_addr`=a, data `~PAT` for M1, PAT for M2; compare `rd_data` against PAT for M1, `~PAT` for M2.
- M3 ↓(r0,w1) and M4 ↓(r1,w0): same as M1/M2 with a = DEPTH-1 down to 0.
- M5 ↑(r0): 1 cycle per address, `rd_en`=1.
  - Compare in the following cycle: pipelined, overlapping the next read.
  - The final compare happens in CHK.
- Read and write never target the same address in the same cycle, so the RAM write-through bypass is never exercised.
- Transitions:
  - IDLE/DONE→M0 on `start`.
  - Each element advances when its last address (and ph=1, where used) completes.
  - M5→CHK→DONE.
- Mismatch in any compare cycle:
  - Next state is DONE with `fail`=1.
  - `fail_addr`/`fail_data`/`fail_exp` are captured from that compare cycle.
  - Any write scheduled in that compare cycle is still issued.
- Only the first mismatch is recorded.
- `start` while `busy` is ignored.
- `start` in DONE clears `done`, `fail` and the three capture registers, and enters M0.

## Timing

- Reset values: `busy`/`done`/`fail`/`wr`/`wr_en`/`rd_en` = 0; `fail_addr`/`fail_data`/`fail_exp`/`wr_addr`/`wr_data`/`rd_addr` = 0. State is IDLE.
- Reset low mid-test aborts immediately: next cycle is the reset state, with no further RAM strobes.
- `start` high at edge k: `busy`=1 and the first M0 write are driven in cycle k+1.
- Busy duration is 10·DEPTH+1 cycles; DEPTH=16 gives 161.
  - M0 = DEPTH cycles.
  - M1–M4 = 2·DEPTH cycles each.
  - M5 = DEPTH cycles.
  - CHK = 1 cycle.
- On pass, `done`=1 and `busy`=0 in the cycle after CHK.
- On abort, `done`=`fail`=1 and `busy`=0 in the cycle after the failing compare.
- Outside the busy window, all RAM strobes are 0.

## Test plan

- Fault-free RAM model, DEPTH=16, PAT=0x00, `start` at cycle 0 → `busy` for cycles 1..161, `done`=1 at cycle 162, `fail`=0, 80 writes and 80 reads issued.
- Bit 0 of word 5 stuck-at-1 → M1 compare at busy-relative cycle 27 mismatches; `fail`=`done`=1 one cycle later; `fail_addr`=5, `fail_data`=0x01, `fail_exp`=0x00.
- Coupling fault where a write of 0xFF to word 9 flips word 8 to 0xFF → caught in M3 (↓) at address 8 with `fail_exp`=0x00, `fail_data`=0xFF; no earlier failure.
- `rst` low at busy-relative cycle 50 → next cycle all outputs at reset values; a later `start` runs a full clean 161-cycle test.
- `start` pulsed repeatedly while busy → ignored, total duration unchanged. `start` in DONE after a fail clears `fail`/`fail_*` and reruns.
- DEPTH=4, PAT=0x5A → 41 busy cycles; writes use 0x5A/0xA5; `wr_addr` never exceeds 3.

Source files
------------

// File: rtl/oc8051_ram_bist_if.sv
// Bus bundle between the March C- BIST engine and its environment:
// the test control/status handshake plus the RAM write and read ports.
interface oc8051_ram_bist_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] fail_addr;
    logic [7:0] fail_data;
    logic [7:0] fail_exp;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr;
    logic       wr_en;
    logic [7:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data;

    // BIST engine side: drives the RAM strobes and status.
    modport master (
        input  start, rd_data,
        output busy, done, fail, fail_addr, fail_data, fail_exp,
        output wr_addr, wr_data, wr, wr_en, rd_addr, rd_en
    );

    // Environment side: issues start, returns RAM read data.
    modport slave (
        output start, rd_data,
        input  busy, done, fail, fail_addr, fail_data, fail_exp,
        input  wr_addr, wr_data, wr, wr_en, rd_addr, rd_en
    );
endinterface

// File: rtl/oc8051_ram_bist.sv
// March C- self-test engine for the 8051 internal data RAM.
// Elements: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0).
// All RAM strobes and status outputs are registered; the next-cycle values
// are decoded from the next state so they line up with the state register.
module oc8051_ram_bist #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] PAT   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    oc8051_ram_bist_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ph_q, ph_d;

    logic          cmp_en_s;
    logic [AW-1:0] cmp_addr_s;
    logic [7:0]    cmp_exp_s;
    logic          mismatch_s;
    logic          start_acc_s;

    logic          wr_d, rd_en_d;
    logic [7:0]    wr_addr_d, wr_data_d, rd_addr_d;

    logic          wr_q, rd_en_q, busy_q, done_q, fail_q;
    logic [7:0]    wr_addr_q, wr_data_q, rd_addr_q;
    logic [7:0]    fail_addr_q, fail_data_q, fail_exp_q;

    // March sequencing: address/sub-phase walk and the compare of each cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ph_d        = ph_q;
        cmp_en_s    = 1'b0;
        cmp_addr_s  = ADDR_ZERO;
        cmp_exp_s   = PAT;
        start_acc_s = 1'b0;
        mismatch_s  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    start_acc_s = 1'b1;
                    state_d     = S_M0;
                    addr_d      = ADDR_ZERO;
                    ph_d        = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_M1;
                    addr_d  = ADDR_ZERO;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_M1, S_M2: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d       = 1'b0;
                    cmp_en_s   = 1'b1;
                    cmp_addr_s = addr_q;
                    cmp_exp_s  = (state_q == S_M1) ? PAT : ~PAT;
                    if (addr_q == ADDR_LAST) begin
                        state_d = (state_q == S_M1) ? S_M2 : S_M3;
                        addr_d  = (state_q == S_M1) ? ADDR_ZERO : ADDR_LAST;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_M3, S_M4: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d       = 1'b0;
                    cmp_en_s   = 1'b1;
                    cmp_addr_s = addr_q;
                    cmp_exp_s  = (state_q == S_M3) ? PAT : ~PAT;
                    if (addr_q == ADDR_ZERO) begin
                        state_d = (state_q == S_M3) ? S_M4 : S_M5;
                        addr_d  = (state_q == S_M3) ? ADDR_LAST : ADDR_ZERO;
                    end else begin
                        addr_d = addr_q - ADDR_ONE;
                    end
                end
            end
            S_M5: begin
                // Read data of the previous address arrives now (pipelined).
                cmp_en_s   = (addr_q != ADDR_ZERO);
                cmp_addr_s = addr_q - ADDR_ONE;
                cmp_exp_s  = PAT;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_CHK;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_CHK: begin
                cmp_en_s   = 1'b1;
                cmp_addr_s = ADDR_LAST;
                cmp_exp_s  = PAT;
                state_d    = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        mismatch_s = cmp_en_s && (bus.rd_data != cmp_exp_s);
        if (mismatch_s) begin
            state_d = S_DONE;
        end else begin
            state_d = state_d;
        end
    end

    // Decode the RAM strobes that belong to the next state.
    always_comb begin
        wr_d      = 1'b0;
        wr_addr_d = 8'h00;
        wr_data_d = 8'h00;
        rd_en_d   = 1'b0;
        rd_addr_d = 8'h00;
        case (state_d)
            S_M0: begin
                wr_d      = 1'b1;
                wr_addr_d = 8'(addr_d);
                wr_data_d = PAT;
            end
            S_M1, S_M2, S_M3, S_M4: begin
                if (ph_d) begin
                    wr_d      = 1'b1;
                    wr_addr_d = 8'(addr_d);
                    wr_data_d = ((state_d == S_M1) || (state_d == S_M3)) ? ~PAT : PAT;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = 8'(addr_d);
                end
            end
            S_M5: begin
                rd_en_d   = 1'b1;
                rd_addr_d = 8'(addr_d);
            end
            default: begin
                wr_d = 1'b0;
            end
        endcase
    end

    // State, strobe and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= ADDR_ZERO;
            ph_q        <= 1'b0;
            wr_q        <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= 8'h00;
            fail_data_q <= 8'h00;
            fail_exp_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ph_q      <= ph_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
            if (start_acc_s) begin
                fail_q      <= 1'b0;
                fail_addr_q <= 8'h00;
                fail_data_q <= 8'h00;
                fail_exp_q  <= 8'h00;
            end else if (mismatch_s) begin
                fail_q      <= 1'b1;
                fail_addr_q <= 8'(cmp_addr_s);
                fail_data_q <= bus.rd_data;
                fail_exp_q  <= cmp_exp_s;
            end else begin
                fail_q <= fail_q;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.fail_data = fail_data_q;
    assign bus.fail_exp  = fail_exp_q;
    assign bus.wr        = wr_q;
    assign bus.wr_en     = wr_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_oc8051_ram_bist.sv
// Bench for oc8051_ram_bist: two instances (DEPTH=16/PAT=00 and DEPTH=4/PAT=5A),
// a behavioural RAM with injectable faults, and an abstract March C- model.
module tb_oc8051_ram_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    oc8051_ram_bist_if ifa ();
    oc8051_ram_bist_if ifb ();

    oc8051_ram_bist #(.DEPTH(16), .PAT(8'h00)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    oc8051_ram_bist #(.DEPTH(4),  .PAT(8'h5A)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int checks = 0;
    int failures = 0;

    // Fault configuration of RAM A: 0 none, 1 stuck bit, 2 coupling.
    int         fk = 0;
    int         sa_addr = 0;
    logic [7:0] sa_mask = 8'h00;
    bit         sa_one = 1'b0;
    int         cf_agg = 0;
    int         cf_vic = 0;
    logic [7:0] cf_trig = 8'hFF;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [4];
    logic [7:0] mdl_mem [256];

    int busy_cnt_a = 0, wr_cnt_a = 0, rd_cnt_a = 0, viol_a = 0;
    int busy_cnt_b = 0, wr_cnt_b = 0, rd_cnt_b = 0, viol_b = 0;

    function automatic logic [7:0] fault_rd(input int a, input logic [7:0] v);
        if (fk == 1 && a == sa_addr) return sa_one ? (v | sa_mask) : (v & ~sa_mask);
        return v;
    endfunction

    // RAM A: registered read, optional faults.
    always @(posedge clk) begin
        if (ifa.rd_en) ifa.rd_data <= fault_rd(int'(ifa.rd_addr), mem_a[ifa.rd_addr[3:0]]);
        if (ifa.wr) begin
            mem_a[ifa.wr_addr[3:0]] <= ifa.wr_data;
            if (fk == 2 && int'(ifa.wr_addr) == cf_agg && ifa.wr_data == cf_trig)
                mem_a[cf_vic[3:0]] <= cf_trig;
        end
    end

    // RAM B: fault-free.
    always @(posedge clk) begin
        if (ifb.rd_en) ifb.rd_data <= mem_b[ifb.rd_addr[1:0]];
        if (ifb.wr) mem_b[ifb.wr_addr[1:0]] <= ifb.wr_data;
    end

    // Bus monitors: count activity and protocol violations.
    always @(negedge clk) begin
        if (ifa.busy === 1'b1) begin
            busy_cnt_a++;
            if (ifa.wr) wr_cnt_a++;
            if (ifa.rd_en) rd_cnt_a++;
        end else if (ifa.wr !== 1'b0 || ifa.rd_en !== 1'b0) viol_a++;
        if (ifa.wr_en !== ifa.wr) viol_a++;
        if (ifa.wr && ifa.rd_en && ifa.wr_addr == ifa.rd_addr) viol_a++;
        if (ifa.wr_addr >= 8'd16 || ifa.rd_addr >= 8'd16) viol_a++;
        if (ifa.wr && ifa.wr_data != 8'h00 && ifa.wr_data != 8'hFF) viol_a++;
    end

    always @(negedge clk) begin
        if (ifb.busy === 1'b1) begin
            busy_cnt_b++;
            if (ifb.wr) wr_cnt_b++;
            if (ifb.rd_en) rd_cnt_b++;
        end else if (ifb.wr !== 1'b0 || ifb.rd_en !== 1'b0) viol_b++;
        if (ifb.wr_en !== ifb.wr) viol_b++;
        if (ifb.wr && ifb.rd_en && ifb.wr_addr == ifb.rd_addr) viol_b++;
        if (ifb.wr_addr > 8'd3 || ifb.rd_addr > 8'd3) viol_b++;
        if (ifb.wr && ifb.wr_data != 8'h5A && ifb.wr_data != 8'hA5) viol_b++;
    end

    function automatic logic [7:0] mdl_read(input int a);
        return fault_rd(a, mdl_mem[a]);
    endfunction

    function automatic void mdl_write(input int a, input logic [7:0] v);
        mdl_mem[a] = v;
        if (fk == 2 && a == cf_agg && v == cf_trig) mdl_mem[cf_vic] = cf_trig;
    endfunction

    // Abstract March C- run: outcome, busy length and strobe counts.
    task automatic model_march(input int d, input logic [7:0] pat, output bit efail,
                               output int ecyc, output logic [7:0] eaddr, output logic [7:0] edata,
                               output logic [7:0] eexp, output int ewr, output int erd);
        int t;
        int a;
        logic [7:0] v, rexp, prev;
        efail = 1'b0; ecyc = 0; eaddr = 8'h00; edata = 8'h00; eexp = 8'h00;
        ewr = 0; erd = 0; t = 0; prev = 8'h00;
        for (int i = 0; i < d; i++) begin mdl_write(i, pat); ewr++; t++; end
        for (int e = 1; e <= 4 && !efail; e++) begin
            for (int k = 0; k < d && !efail; k++) begin
                a = (e <= 2) ? k : d - 1 - k;
                rexp = (e == 1 || e == 3) ? pat : ~pat;
                v = mdl_read(a); erd++; t++;
                mdl_write(a, ~rexp); ewr++;
                if (v !== rexp) begin
                    efail = 1'b1; ecyc = t + 1; eaddr = 8'(a); edata = v; eexp = rexp;
                end
                t++;
            end
        end
        for (int i = 0; i <= d && !efail; i++) begin
            if (i > 0 && prev !== pat) begin
                efail = 1'b1; ecyc = t + i + 1; eaddr = 8'(i - 1); edata = prev; eexp = pat;
            end
            if (i < d) begin prev = mdl_read(i); erd++; end
        end
        if (!efail) ecyc = t + d + 1;
    endtask

    task automatic pulse_start_a();
        @(negedge clk); ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
    endtask

    task automatic wait_done_a(output bit to);
        int n = 0;
        to = 1'b0;
        while (ifa.done !== 1'b1) begin
            @(negedge clk); n++;
            if (n > 2000) begin to = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; ifa.start = 1'b0; ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.busy, ifa.done, ifa.fail, ifa.wr, ifa.wr_en, ifa.rd_en} !== 6'b0) begin
            failures++; $display("FAIL reset_ctl_a got=%b exp=000000", {ifa.busy, ifa.done, ifa.fail, ifa.wr, ifa.wr_en, ifa.rd_en});
        end
        checks++;
        if ({ifa.fail_addr, ifa.fail_data, ifa.fail_exp, ifa.wr_addr, ifa.wr_data, ifa.rd_addr} !== 48'h0) begin
            failures++; $display("FAIL reset_bus_a got=%h exp=0", {ifa.fail_addr, ifa.fail_data, ifa.fail_exp, ifa.wr_addr, ifa.wr_data, ifa.rd_addr});
        end
        checks++;
        if ({ifb.busy, ifb.done, ifb.fail, ifb.wr, ifb.rd_en, ifb.wr_addr, ifb.wr_data} !== 21'h0) begin
            failures++; $display("FAIL reset_b got=%h exp=0", {ifb.busy, ifb.done, ifb.fail, ifb.wr, ifb.rd_en, ifb.wr_addr, ifb.wr_data});
        end
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0/0", ifa.busy, ifa.done);
        end
    endtask

    task automatic test_clean16();
        bit ef, to; int ec, ew, er, b0, w0, r0; logic [7:0] ea, ed, ee;
        fk = 0;
        model_march(16, 8'h00, ef, ec, ea, ed, ee, ew, er);
        b0 = busy_cnt_a; w0 = wr_cnt_a; r0 = rd_cnt_a;
        pulse_start_a();
        checks++;
        if (ifa.busy !== 1'b1 || ifa.wr !== 1'b1 || ifa.wr_addr !== 8'h00 || ifa.wr_data !== 8'h00) begin
            failures++; $display("FAIL first_write got busy=%b wr=%b addr=%h data=%h exp 1/1/00/00", ifa.busy, ifa.wr, ifa.wr_addr, ifa.wr_data);
        end
        wait_done_a(to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL clean_timeout got=%b exp=0", to); end
        checks++;
        if (busy_cnt_a - b0 != ec || ec != 161) begin
            failures++; $display("FAIL clean_busy_len got=%0d exp=%0d (161)", busy_cnt_a - b0, ec);
        end
        checks++; if (ifa.fail !== ef) begin failures++; $display("FAIL clean_fail got=%b exp=%b", ifa.fail, ef); end
        checks++;
        if (wr_cnt_a - w0 != ew || rd_cnt_a - r0 != er || ew != 80 || er != 80) begin
            failures++; $display("FAIL clean_counts got wr=%0d rd=%0d exp wr=%0d rd=%0d", wr_cnt_a - w0, rd_cnt_a - r0, ew, er);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.fail !== 1'b0) begin
            failures++; $display("FAIL done_held got done=%b busy=%b fail=%b exp 1/0/0", ifa.done, ifa.busy, ifa.fail);
        end
    endtask

    task automatic run_fault_case(input string name, input bit use_const, input int c_cyc,
                                  input logic [7:0] c_addr, input logic [7:0] c_data, input logic [7:0] c_exp);
        bit ef, to; int ec, ew, er, b0; logic [7:0] ea, ed, ee;
        model_march(16, 8'h00, ef, ec, ea, ed, ee, ew, er);
        if (use_const) begin ec = c_cyc; ea = c_addr; ed = c_data; ee = c_exp; ef = 1'b1; end
        b0 = busy_cnt_a;
        pulse_start_a();
        wait_done_a(to);
        checks++;
        if (to !== 1'b0 || busy_cnt_a - b0 != ec) begin
            failures++; $display("FAIL %s_len got=%0d exp=%0d timeout=%b", name, busy_cnt_a - b0, ec, to);
        end
        checks++;
        if (ifa.fail !== ef || (ef && (ifa.fail_addr !== ea || ifa.fail_data !== ed || ifa.fail_exp !== ee))) begin
            failures++; $display("FAIL %s_capture got fail=%b a=%h d=%h e=%h exp fail=%b a=%h d=%h e=%h",
                                 name, ifa.fail, ifa.fail_addr, ifa.fail_data, ifa.fail_exp, ef, ea, ed, ee);
        end
    endtask

    task automatic test_stuck_spec();
        fk = 1; sa_addr = 5; sa_mask = 8'h01; sa_one = 1'b1;
        run_fault_case("stuck5", 1'b1, 28, 8'h05, 8'h01, 8'h00);
    endtask

    task automatic test_coupling_spec();
        fk = 2; cf_agg = 9; cf_vic = 8; cf_trig = 8'hFF;
        run_fault_case("coupling98", 1'b1, 96, 8'h08, 8'hFF, 8'h00);
    endtask

    task automatic test_rerun_after_fail();
        bit to; int b0;
        fk = 0;
        b0 = busy_cnt_a;
        pulse_start_a();
        checks++;
        if ({ifa.done, ifa.fail, ifa.fail_addr, ifa.fail_data, ifa.fail_exp} !== 26'h0 || ifa.busy !== 1'b1) begin
            failures++; $display("FAIL rerun_clear got done=%b fail=%b a=%h d=%h e=%h busy=%b exp 0/0/00/00/00/1",
                                 ifa.done, ifa.fail, ifa.fail_addr, ifa.fail_data, ifa.fail_exp, ifa.busy);
        end
        wait_done_a(to);
        checks++;
        if (to !== 1'b0 || ifa.fail !== 1'b0 || busy_cnt_a - b0 != 161) begin
            failures++; $display("FAIL rerun_pass got fail=%b len=%0d exp 0/161", ifa.fail, busy_cnt_a - b0);
        end
    endtask

    task automatic test_random_faults();
        for (int it = 0; it < 10; it++) begin
            fk = int'($urandom_range(0, 2));
            sa_addr = int'($urandom_range(0, 15));
            sa_mask = 8'h01 << $urandom_range(0, 7);
            sa_one = 1'($urandom_range(0, 1));
            cf_agg = int'($urandom_range(0, 15));
            cf_vic = (cf_agg + int'($urandom_range(1, 15))) % 16;
            cf_trig = 8'hFF;
            run_fault_case("random", 1'b0, 0, 8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic test_reset_midrun();
        bit to; int b0;
        fk = 0;
        pulse_start_a();
        repeat (50) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifa.busy, ifa.done, ifa.fail, ifa.wr, ifa.wr_en, ifa.rd_en, ifa.wr_addr, ifa.wr_data, ifa.rd_addr} !== 30'h0) begin
            failures++; $display("FAIL midrun_reset got busy=%b wr=%b rd=%b wa=%h wd=%h ra=%h exp all 0",
                                 ifa.busy, ifa.wr, ifa.rd_en, ifa.wr_addr, ifa.wr_data, ifa.rd_addr);
        end
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk);
        b0 = busy_cnt_a;
        pulse_start_a();
        wait_done_a(to);
        checks++;
        if (to !== 1'b0 || ifa.fail !== 1'b0 || busy_cnt_a - b0 != 161) begin
            failures++; $display("FAIL after_reset_run got fail=%b len=%0d exp 0/161", ifa.fail, busy_cnt_a - b0);
        end
    endtask

    task automatic test_start_while_busy();
        bit to; int b0;
        fk = 0;
        b0 = busy_cnt_a;
        pulse_start_a();
        for (int p = 0; p < 10; p++) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            ifa.start = 1'b1;
            @(negedge clk);
            ifa.start = 1'b0;
        end
        wait_done_a(to);
        checks++;
        if (to !== 1'b0 || ifa.fail !== 1'b0 || busy_cnt_a - b0 != 161) begin
            failures++; $display("FAIL start_busy got fail=%b len=%0d exp 0/161", ifa.fail, busy_cnt_a - b0);
        end
    endtask

    task automatic test_depth4();
        bit ef, to; int ec, ew, er, b0, w0, r0, n; logic [7:0] ea, ed, ee;
        fk = 0;
        model_march(4, 8'h5A, ef, ec, ea, ed, ee, ew, er);
        b0 = busy_cnt_b; w0 = wr_cnt_b; r0 = rd_cnt_b;
        @(negedge clk); ifb.start = 1'b1;
        @(negedge clk); ifb.start = 1'b0;
        checks++;
        if (ifb.busy !== 1'b1 || ifb.wr !== 1'b1 || ifb.wr_data !== 8'h5A) begin
            failures++; $display("FAIL d4_first got busy=%b wr=%b data=%h exp 1/1/5a", ifb.busy, ifb.wr, ifb.wr_data);
        end
        n = 0; to = 1'b0;
        while (ifb.done !== 1'b1) begin
            @(negedge clk); n++;
            if (n > 500) begin to = 1'b1; break; end
        end
        checks++;
        if (to !== 1'b0 || busy_cnt_b - b0 != ec || ec != 41 || ifb.fail !== 1'b0) begin
            failures++; $display("FAIL d4_len got=%0d exp=%0d (41) fail=%b", busy_cnt_b - b0, ec, ifb.fail);
        end
        checks++;
        if (wr_cnt_b - w0 != ew || rd_cnt_b - r0 != er) begin
            failures++; $display("FAIL d4_counts got wr=%0d rd=%0d exp wr=%0d rd=%0d", wr_cnt_b - w0, rd_cnt_b - r0, ew, er);
        end
    endtask

    task automatic test_protocol();
        checks++; if (viol_a != 0) begin failures++; $display("FAIL protocol_a got=%0d exp=0", viol_a); end
        checks++; if (viol_b != 0) begin failures++; $display("FAIL protocol_b got=%0d exp=0", viol_b); end
    endtask

    initial begin
        test_reset();
        test_clean16();
        test_stuck_spec();
        test_rerun_after_fail();
        test_coupling_spec();
        test_random_faults();
        test_reset_midrun();
        test_start_while_busy();
        test_depth4();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
